transposed_fir_filter: RTL and testbench

Six-tap transposed-form FIR filter with a double-buffered coefficient bank and a valid-qualified sample stream. It computes the same convolution as the team's direct-form filter, with the data flow reversed: the input sample is broadcast to all multipliers and partial sums ripple toward the output. This gives a single adder stage per tap and one-cycle latency. Coefficient updates are glitch-free: they are staged in a shadow bank and applied atomically between samples.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_coef_bank.sv | 45 ++++
 rtl/transposed_fir_filter.sv | 106 ++++++++++
 tb/tb_transposed_fir_filter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared sizing and types for the transposed-form FIR filter.
package fir_pkg;

   localparam int unsigned DefTaps = 6;
   localparam int unsigned DefDw   = 16;
   localparam int unsigned DefCw   = 14;
   localparam int unsigned DefOw   = DefDw + DefCw + 3;

   typedef logic signed [DefDw-1:0] sample_t;
   typedef logic signed [DefCw-1:0] coef_t;
   typedef logic signed [DefOw-1:0] acc_t;
   typedef logic [DefTaps-1:0][DefCw-1:0] coef_arr_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage: writes land in a shadow bank and a commit
// copies the whole shadow bank into the active bank in one edge.
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int unsigned TAPS = DefTaps,
   parameter int unsigned CW   = DefCw
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we_i,
   input  logic [2:0]                 addr_i,
   input  logic [CW-1:0]              data_i,
   input  logic                       commit_i,
   output logic [TAPS-1:0][CW-1:0]    active_o
);

   logic [TAPS-1:0][CW-1:0] shadow_q, shadow_d;
   logic [TAPS-1:0][CW-1:0] active_q, active_d;

   always_comb begin
      shadow_d = shadow_q;
      // Full-width address compare so out-of-range addresses never alias onto a tap.
      for (int k = 0; k < int'(TAPS); k++) begin
         if (we_i && (addr_i == 3'(k))) begin
            shadow_d[k] = data_i;
         end
      end
      // Commit copies the pre-write shadow contents.
      active_d = commit_i ? shadow_q : active_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign active_o = active_q;

endmodule

// File: rtl/transposed_fir_filter.sv
// Transposed-form FIR: each sample is broadcast to every tap multiplier and partial
// sums ripple toward the output register, giving one adder per stage and 1-cycle latency.
module transposed_fir_filter
   import fir_pkg::*;
#(
   parameter int unsigned TAPS = DefTaps,
   parameter int unsigned DW   = DefDw,
   parameter int unsigned CW   = DefCw,
   parameter int unsigned OW   = DW + CW + 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [DW-1:0]        a,
   input  logic                 coef_we,
   input  logic [2:0]           coef_addr,
   input  logic [CW-1:0]        coef_data,
   input  logic                 coef_commit,
   input  logic                 flush,
   output logic                 out_valid,
   output logic [OW-1:0]        b,
   output logic                 primed
);

   localparam int unsigned PW   = DW + CW;
   localparam int unsigned CntW = $clog2(TAPS + 1);

   logic [TAPS-1:0][CW-1:0] coef;

   logic signed [PW-1:0] mult [TAPS];
   logic signed [OW-1:0] prod [TAPS];

   logic signed [OW-1:0] s_q [1:TAPS-1];
   logic signed [OW-1:0] s_d [1:TAPS-1];
   logic signed [OW-1:0] b_q, b_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic                 primed_q, primed_d;

   fir_coef_bank #(
      .TAPS (TAPS),
      .CW   (CW)
   ) u_coef_bank (
      .clk      (clk),
      .reset    (reset),
      .we_i     (coef_we),
      .addr_i   (coef_addr),
      .data_i   (coef_data),
      .commit_i (coef_commit),
      .active_o (coef)
   );

   always_comb begin
      for (int k = 0; k < int'(TAPS); k++) begin
         mult[k] = PW'($signed(coef[k])) * PW'($signed(a));
         prod[k] = OW'(mult[k]);
      end
   end

   always_comb begin
      s_d         = s_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      if (flush) begin
         for (int k = 1; k < int'(TAPS); k++) begin
            s_d[k] = '0;
         end
         cnt_d = '0;
      end else if (in_valid) begin
         s_d[TAPS-1] = prod[TAPS-1];
         for (int k = 1; k < int'(TAPS) - 1; k++) begin
            s_d[k] = prod[k] + s_q[k+1];
         end
         b_d         = prod[0] + s_q[1];
         out_valid_d = 1'b1;
         if (cnt_q != CntW'(TAPS)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      primed_d = (cnt_d == CntW'(TAPS));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 1; k < int'(TAPS); k++) begin
            s_q[k] <= '0;
         end
         b_q         <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         primed_q    <= 1'b0;
      end else begin
         s_q         <= s_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         primed_q    <= primed_d;
      end
   end

   assign b         = b_q;
   assign out_valid = out_valid_q;
   assign primed    = primed_q;

endmodule

// File: tb/tb_transposed_fir_filter.sv
// Directed bench for transposed_fir_filter with hand-computed expected outputs.
module tb_transposed_fir_filter;
   import fir_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   sample_t    a;
   logic       coef_we;
   logic [2:0] coef_addr;
   coef_t      coef_data;
   logic       coef_commit;
   logic       flush;
   logic       out_valid;
   acc_t       b;
   logic       primed;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   transposed_fir_filter dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .a           (a),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_data   (coef_data),
      .coef_commit (coef_commit),
      .flush       (flush),
      .out_valid   (out_valid),
      .b           (b),
      .primed      (primed)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input int addr, input int data);
      coef_we   = 1'b1;
      coef_addr = 3'(addr);
      coef_data = coef_t'(data);
      tick();
      coef_we   = 1'b0;
   endtask

   task automatic load_all(input int data);
      for (int k = 0; k < 6; k++) wr(k, data);
   endtask

   task automatic commit();
      coef_commit = 1'b1;
      tick();
      coef_commit = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic sample(input int v);
      in_valid = 1'b1;
      a        = sample_t'(v);
      tick();
      in_valid = 1'b0;
   endtask

   int imp [7] = '{1, 0, 0, 0, 0, 0, 0};
   int exp [7] = '{1, 2, 3, 4, 5, 6, 0};

   initial begin
      reset       = 1'b0;
      in_valid    = 1'b1;
      a           = 16'sd100;
      coef_we     = 1'b0;
      coef_addr   = '0;
      coef_data   = '0;
      coef_commit = 1'b0;
      flush       = 1'b0;

      // Reset held with a live sample stream
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_b", b, 0);
         chk("reset_out_valid", out_valid, 0);
         chk("reset_primed", primed, 0);
      end
      reset    = 1'b1;
      in_valid = 1'b0;

      // Impulse response
      for (int k = 0; k < 6; k++) wr(k, k + 1);
      commit();
      for (int i = 0; i < 7; i++) begin
         sample(imp[i]);
         chk("impulse_b", b, exp[i]);
         chk("impulse_out_valid", out_valid, 1);
         chk("impulse_primed", primed, (i >= 5) ? 1 : 0);
      end

      // Gapped stream after a flush
      do_flush();
      chk("flush_primed", primed, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_b_hold", b, 0);
      for (int i = 0; i < 7; i++) begin
         sample(imp[i]);
         chk("gap_b", b, exp[i]);
         chk("gap_out_valid", out_valid, 1);
         for (int j = 0; j < 2; j++) begin
            tick();
            chk("gap_idle_out_valid", out_valid, 0);
            chk("gap_idle_b_hold", b, exp[i]);
         end
      end

      // Extremes: full precision, no wrap
      load_all(-8192);
      commit();
      do_flush();
      for (int i = 0; i < 6; i++) sample(-32768);
      chk("extreme_neg_b", b, 64'sd1610612736);
      chk("extreme_primed", primed, 1);
      for (int i = 0; i < 6; i++) sample(32767);
      chk("extreme_pos_b", b, -64'sd1610563584);

      // Commit racing a sample and a coefficient write
      load_all(1);
      commit();
      load_all(2);
      do_flush();
      coef_commit = 1'b1;
      coef_we     = 1'b1;
      coef_addr   = 3'd0;
      coef_data   = 14'sd7;
      in_valid    = 1'b1;
      a           = 16'sd10;
      tick();
      coef_commit = 1'b0;
      coef_we     = 1'b0;
      chk("race_old_bank_b", b, 10);
      tick();
      in_valid = 1'b0;
      chk("race_new_bank_b", b, 30);
      do_flush();
      sample(1);
      chk("race_write_not_committed", b, 2);
      commit();
      do_flush();
      sample(1);
      chk("race_write_second_commit", b, 7);

      // Flush mid-stream drops the concurrent sample
      load_all(1);
      commit();
      do_flush();
      for (int i = 1; i <= 3; i++) begin
         sample(5);
         chk("mid_b", b, 5 * i);
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      a        = 16'sd7;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("mid_flush_out_valid", out_valid, 0);
      chk("mid_flush_primed", primed, 0);
      chk("mid_flush_b_hold", b, 15);
      sample(1);
      chk("mid_after_flush_b", b, 1);
      chk("mid_after_flush_primed", primed, 0);

      // Reset mid-stream clears coefficients; out-of-range writes are ignored
      sample(5);
      reset    = 1'b0;
      in_valid = 1'b1;
      a        = 16'sd9;
      tick();
      reset    = 1'b1;
      in_valid = 1'b0;
      chk("midreset_b", b, 0);
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_primed", primed, 0);
      wr(6, 5);
      wr(7, 5);
      commit();
      sample(3);
      chk("oob_write_b", b, 0);
      chk("oob_write_out_valid", out_valid, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
